// File: rtl/ext_alu_sequencer_pkg.sv
// Shared types and constants for the extended-ALU sequencer and the
// surrounding execute-stage datapath (operand forwarding, M-stage bubbles).
package ext_alu_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Operand-mux select encodings shared with the hazard/forwarding unit
  typedef enum logic [1:0] {
    FWD_REGFILE = 2'b00,
    FWD_WB      = 2'b01,
    FWD_MEM     = 2'b10
  } fwd_sel_t;

  // Level on bubble_m that forces RegWriteM/MemWriteM to zero
  localparam logic BUBBLE_NOP = 1'b1;

endpackage

// File: rtl/ext_alu_sequencer_if.sv
// Pipeline-side bundle of the extended-ALU sequencer: issue/kill/done in,
// stall/bubble/select/status out.
interface ext_alu_sequencer_if;
  logic       issue_valid;
  logic       issue_opt;
  logic [4:0] issue_rd;
  logic       kill;
  logic       ext_done;

  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       bubble_m;
  logic       alu_sel;
  logic       ext_start;
  logic       ext_abort;
  logic       busy;
  logic [4:0] busy_rd;
  logic       timeout_err;

  modport master (
    output issue_valid, issue_opt, issue_rd, kill, ext_done,
    input  stall_f, stall_d, stall_e, bubble_m, alu_sel,
    input  ext_start, ext_abort, busy, busy_rd, timeout_err
  );

  modport slave (
    input  issue_valid, issue_opt, issue_rd, kill, ext_done,
    output stall_f, stall_d, stall_e, bubble_m, alu_sel,
    output ext_start, ext_abort, busy, busy_rd, timeout_err
  );
endinterface

// File: rtl/ext_alu_sequencer_lat_counter.sv
// Latency/timeout counter for the extended-ALU sequencer: load, count down
// to zero (fixed latency) or count up to a limit (done/timeout mode).
module ext_lat_counter #(
  parameter int CW    = 4,
  parameter int LIMIT = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  input  logic          i_inc,
  output logic          o_zero,
  output logic          o_limit
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec) begin
      r_count <= r_count - CW'(1);
    end else if (i_inc) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_zero  = (r_count == '0);
  assign o_limit = (r_count == CW'(LIMIT));

endmodule

// File: rtl/ext_alu_sequencer.sv
// Execute-stage sequencer for the multi-cycle extended ALU.
// States: IDLE await hit | START pulse ext_start | WAIT run unit | DONE capture cycle.
module ext_alu_sequencer
  import ext_alu_sequencer_pkg::*;
#(
  parameter int LATENCY  = 3,
  parameter int USE_DONE = 0,
  parameter int TIMEOUT  = 15,
  parameter int CW       = $clog2(TIMEOUT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  ext_alu_sequencer_if.slave  bus
);

  localparam bit DONE_MODE = (USE_DONE != 0);

  seq_state_t    r_state;
  seq_state_t    w_next;
  logic [4:0]    r_busy_rd;
  logic          r_timeout_err;

  logic          w_hit;
  logic          w_zero;
  logic          w_limit;
  logic          w_wait_end;
  logic          w_timeout;
  logic          w_cnt_load;
  logic          w_cnt_dec;
  logic          w_cnt_inc;
  logic [CW-1:0] w_cnt_load_val;

  logic          w_stall;
  logic          w_bubble;
  logic          w_alu_sel;
  logic          w_start;
  logic          w_abort;
  logic          w_busy;

  // Gated by rst so every output is quiet while reset is held
  assign w_hit = bus.issue_valid & bus.issue_opt & ~bus.kill & rst;

  assign w_wait_end = DONE_MODE ? (bus.ext_done | w_limit) : w_zero;
  assign w_timeout  = DONE_MODE & (r_state == ST_WAIT) & ~bus.kill
                      & ~bus.ext_done & w_limit;

  assign w_cnt_load     = (r_state == ST_START);
  assign w_cnt_load_val = DONE_MODE ? '0 : CW'(LATENCY - 1);
  assign w_cnt_dec      = (r_state == ST_WAIT) & ~DONE_MODE & ~w_zero;
  assign w_cnt_inc      = (r_state == ST_WAIT) & DONE_MODE & ~bus.ext_done & ~w_limit;

  ext_lat_counter #(
    .CW    (CW),
    .LIMIT (TIMEOUT - 1)
  ) u_lat_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .i_inc      (w_cnt_inc),
    .o_zero     (w_zero),
    .o_limit    (w_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_hit) w_next = ST_START;
      ST_START: w_next = bus.kill ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (bus.kill) begin
          w_next = ST_IDLE;
        end else if (w_wait_end) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // A kill in DONE keeps the pipeline frozen so the aborted result is dropped
  always_comb begin
    w_stall   = 1'b0;
    w_bubble  = ~BUBBLE_NOP;
    w_alu_sel = 1'b0;
    w_start   = 1'b0;
    w_abort   = 1'b0;
    w_busy    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall  = w_hit;
        w_bubble = w_hit ? BUBBLE_NOP : ~BUBBLE_NOP;
      end
      ST_START: begin
        w_stall  = 1'b1;
        w_bubble = BUBBLE_NOP;
        w_busy   = 1'b1;
        w_start  = ~bus.kill;
        w_abort  = bus.kill;
      end
      ST_WAIT: begin
        w_stall  = 1'b1;
        w_bubble = BUBBLE_NOP;
        w_busy   = 1'b1;
        w_abort  = bus.kill;
      end
      ST_DONE: begin
        w_stall   = bus.kill;
        w_bubble  = bus.kill ? BUBBLE_NOP : ~BUBBLE_NOP;
        w_alu_sel = ~bus.kill;
        w_busy    = 1'b1;
        w_abort   = bus.kill;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy_rd <= '0;
    end else if (r_state == ST_IDLE) begin
      r_busy_rd <= w_hit ? bus.issue_rd : 5'd0;
    end else if (w_next == ST_IDLE) begin
      r_busy_rd <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign bus.stall_f     = w_stall;
  assign bus.stall_d     = w_stall;
  assign bus.stall_e     = w_stall;
  assign bus.bubble_m    = w_bubble;
  assign bus.alu_sel     = w_alu_sel;
  assign bus.ext_start   = w_start;
  assign bus.ext_abort   = w_abort;
  assign bus.busy        = w_busy;
  assign bus.busy_rd     = r_busy_rd;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ext_alu_sequencer.sv
// Bench for ext_alu_sequencer: counter-mode and done-mode instances driven in
// parallel, compared every cycle against an operation-age reference model.
module tb_ext_alu_sequencer;

  localparam int LAT = 3;
  localparam int TMO = 15;
  localparam int NEVER = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       t_valid = 1'b0;
  logic       t_opt   = 1'b0;
  logic [4:0] t_rd    = '0;
  logic       t_kill  = 1'b0;
  logic       t_done  = 1'b0;

  ext_alu_sequencer_if if0 ();
  ext_alu_sequencer_if if1 ();

  assign if0.issue_valid = t_valid;
  assign if0.issue_opt   = t_opt;
  assign if0.issue_rd    = t_rd;
  assign if0.kill        = t_kill;
  assign if0.ext_done    = t_done;
  assign if1.issue_valid = t_valid;
  assign if1.issue_opt   = t_opt;
  assign if1.issue_rd    = t_rd;
  assign if1.kill        = t_kill;
  assign if1.ext_done    = t_done;

  ext_alu_sequencer #(.LATENCY(LAT), .USE_DONE(0), .TIMEOUT(TMO)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );
  ext_alu_sequencer #(.LATENCY(LAT), .USE_DONE(1), .TIMEOUT(TMO)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );

  // {stall_f,stall_d,stall_e,bubble_m,alu_sel,ext_start,ext_abort,busy,busy_rd,timeout_err}
  logic [13:0] obs0, obs1;
  assign obs0 = {if0.stall_f, if0.stall_d, if0.stall_e, if0.bubble_m, if0.alu_sel,
                 if0.ext_start, if0.ext_abort, if0.busy, if0.busy_rd, if0.timeout_err};
  assign obs1 = {if1.stall_f, if1.stall_d, if1.stall_e, if1.bubble_m, if1.alu_sel,
                 if1.ext_start, if1.ext_abort, if1.busy, if1.busy_rd, if1.timeout_err};

  // Model: age 0 = no op; age 1 = start cycle; capture cycle when age == done_at
  int         age     [2];
  int         done_at [2];
  logic [4:0] mrd     [2];
  logic       merr    [2];

  int n_vec    = 0;
  int n_err    = 0;
  int n_start0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] exp_out(input int m);
    logic hit;
    hit = t_valid & t_opt & ~t_kill;
    if (!rst) return '0;
    if (age[m] == 0)
      return {{3{hit}}, hit, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, merr[m]};
    if (age[m] == done_at[m])
      return {{3{t_kill}}, t_kill, ~t_kill, 1'b0, t_kill, 1'b1, mrd[m], merr[m]};
    return {3'b111, 1'b1, 1'b0, (age[m] == 1) & ~t_kill, t_kill, 1'b1, mrd[m], merr[m]};
  endfunction

  task automatic advance();
    for (int m = 0; m < 2; m++) begin
      if (!rst) begin
        age[m] = 0; mrd[m] = '0; merr[m] = 1'b0; done_at[m] = NEVER;
      end else if (age[m] == 0) begin
        if (t_valid & t_opt & ~t_kill) begin
          age[m]     = 1;
          mrd[m]     = t_rd;
          done_at[m] = (m == 0) ? LAT + 2 : NEVER;
        end
      end else if (t_kill || age[m] == done_at[m]) begin
        age[m] = 0; mrd[m] = '0;
      end else begin
        if (m == 1 && age[m] >= 2) begin
          if (t_done) begin
            done_at[m] = age[m] + 1;
          end else if (age[m] - 1 == TMO) begin
            merr[m]    = 1'b1;
            done_at[m] = age[m] + 1;
          end
        end
        age[m]++;
      end
    end
  endtask

  // Called just after a negedge with inputs already applied
  task automatic step();
    #2;
    chk("dut0 outputs", obs0, exp_out(0));
    chk("dut1 outputs", obs1, exp_out(1));
    if (if0.ext_start) n_start0++;
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic o, input logic [4:0] rd,
                     input logic k, input logic d);
    t_valid = v; t_opt = o; t_rd = rd; t_kill = k; t_done = d;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      age[m] = 0; mrd[m] = '0; merr[m] = 1'b0; done_at[m] = NEVER;
    end
    @(negedge clk);
    step();
    step();
    rst = 1'b1;
    idle(2);

    // Single op rd=7; done-mode unit reports done in its 4th WAIT cycle
    drv(1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
    idle(4);
    drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(3);

    // Back-to-back ops rd=3 then rd=4 (second presented during DONE)
    n_start0 = 0;
    drv(1'b1, 1'b1, 5'd3, 1'b0, 1'b0);
    idle(3);
    drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    drv(1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 5'd4, 1'b0, 1'b0);
    idle(3);
    drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(3);
    chk("b2b start pulses", n_start0, 2);

    // Done-mode timeout: no ext_done ever
    drv(1'b1, 1'b1, 5'd12, 1'b0, 1'b0);
    idle(20);
    chk("timeout_err sticky", if1.timeout_err, 1'b1);

    // Kill in 2nd WAIT cycle, then a normal op
    drv(1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    idle(2);
    drv(1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(1);
    drv(1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    idle(4);
    drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(3);

    // Async reset during WAIT with the op held in E, then re-detect
    drv(1'b1, 1'b1, 5'd21, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 5'd21, 1'b0, 1'b0);
    drv(1'b1, 1'b1, 5'd21, 1'b0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    chk("dut0 async reset", obs0, 14'd0);
    chk("dut1 async reset", obs1, 14'd0);
    @(posedge clk);
    advance();
    @(negedge clk);
    step();
    rst = 1'b1;
    drv(1'b1, 1'b1, 5'd21, 1'b0, 1'b0);
    repeat (4) drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
